instr_fetch_unit: RTL

//  Owns the PC and fetches 32-bit MIPS words from instruction memory through a req/ready handshake.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: owns the PC, fetches words over a req/ready
// handshake and hands them to the decoder over valid/ack, then resolves the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [2:0]  pc_control,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERR} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;
    logic        ctl_bad;

    // Branch target is relative to pc+4, which link_addr already holds.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base + $unsigned(offset);
    endfunction

    always_comb begin
        next_pc = link_addr;
        ctl_bad = pc_control[2];
        case (pc_control)
            3'b001:  next_pc = {link_addr[31:28], instr[25:0], 2'b00};
            3'b010:  next_pc = rs_data;
            3'b011:  next_pc = branch_target(link_addr, instr[15:0]);
            default: next_pc = link_addr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            link_addr <= RESET_PC + 32'd4;
            instr     <= 32'h0;
            fetch_err <= 1'b0;
            err_code  <= 2'b00;
            wait_cnt  <= 8'h0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        instr    <= imem_rdata;
                        wait_cnt <= 8'h0;
                        state    <= ISSUE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        wait_cnt  <= 8'h0;
                        fetch_err <= 1'b1;
                        err_code  <= 2'b01;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (instr_ack) begin
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            err_code  <= 2'b10;
                            state     <= ERR;
                        end else begin
                            pc        <= next_pc;
                            link_addr <= next_pc + 32'd4;
                            state     <= FETCH;
                            // Unknown control is only a warning; the sequential path was taken.
                            if (ctl_bad) begin
                                fetch_err <= 1'b1;
                                err_code  <= 2'b11;
                            end
                        end
                    end
                end
                ERR: state <= ERR;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == ISSUE);
    assign imem_addr   = pc;

endmodule
